w0rm_core_regfile_scoreboard: RTL and testbench
===============================================

W0RM_CORE_REGFILE_SCOREBOARD -- requirements
Module: w0rm_core_regfile_scoreboard

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-002 SHALL have parameter NUM_REGISTERS, default 16, register count; power of two, >= 2.
REQ-003 SHALL have parameter NUM_READ_PORTS, default 2, independent read ports, >= 1.
REQ-004 SHALL have parameter NUM_WRITE_PORTS, default 2, independent write ports, >= 1.
REQ-005 SHALL have parameter ZERO_REG, default 1; when 1, register 0 is hardwired zero.
REQ-006 SHALL derive localparam A = ceil(log2(NUM_REGISTERS)) and C = A+1.
REQ-007 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-008 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-009 SHALL have port rd_addr  in  NUM_READ_PORTS*A  read addresses; port i at bits [i*A +: A].
REQ-010 SHALL have port rd_data  out  NUM_READ_PORTS*DATA_WIDTH  registered read data, port i at [i*DATA_WIDTH +: DATA_WIDTH].
REQ-011 SHALL have port rd_pending  out  NUM_READ_PORTS  registered per-port "operand not yet written" flag.
REQ-012 SHALL have port wr_enable  in  NUM_WRITE_PORTS  per-port write strobe.
REQ-013 SHALL have port wr_addr  in  NUM_WRITE_PORTS*A  write addresses, packed as rd_addr.
REQ-014 SHALL have port wr_data  in  NUM_WRITE_PORTS*DATA_WIDTH  write data, packed as rd_data.
REQ-015 SHALL have port rsv_enable  in  1  request to mark rsv_addr pending.
REQ-016 SHALL have port rsv_addr  in  A  register to reserve.
REQ-017 SHALL have port rsv_grant  out  1  combinational reserve acceptance.
REQ-018 SHALL have port flush  in  1  clear all pending marks.
REQ-019 SHALL have port pending_count  out  C  registered count of pending registers.

Function
REQ-020 Read latency SHALL be one cycle: rd_data port i at t+1 reflects rd_addr port i sampled at t.
REQ-021 Write-before-read: if any wr_enable[j] at t with wr_addr[j]==rd_addr[i], rd_data[i] at t+1 SHALL be wr_data of the highest such j.
REQ-022 Multiple writes to one address in one cycle: highest write-port index SHALL win in the array.
REQ-023 ZERO_REG=1: reads of register 0 SHALL return 0; writes to 0 SHALL be ignored and never bypassed.
REQ-024 Each register SHALL carry one pending bit, set by a granted reserve, cleared by any write to it.
REQ-025 rsv_grant SHALL equal rsv_enable AND NOT pending[rsv_addr] AND NOT flush, using pre-edge state; rejected reserves change nothing.
REQ-026 Reserve of register 0 with ZERO_REG=1 SHALL be granted but SHALL NOT set pending.
REQ-027 Granted reserve and write to the same register in one cycle: pending SHALL end set (reserve wins).
REQ-028 flush SHALL clear all pending bits at the edge, overriding same-cycle reserves; register contents unaffected.
REQ-029 rd_pending[i] at t+1 SHALL equal pending[rd_addr[i]] after the edge-t update (same-cycle write clears, reserve sets).
REQ-030 pending_count SHALL equal the number of set pending bits after each edge; range 0..NUM_REGISTERS, no wrap.
REQ-031 Writes to non-pending registers SHALL update data and leave pending_count unchanged.

Reset
REQ-032 While reset_n=0: all registers, rd_data, rd_pending, pending bits and pending_count SHALL be 0, independent of clk.
REQ-033 Writes, reserves and flush during reset SHALL be ignored; rsv_grant SHALL be 0.
REQ-034 First read after reset_n rises SHALL return 0 with rd_pending 0.
REQ-035 Reset asserted mid-operation SHALL discard all pending marks and data immediately.

Verification
REQ-036 Write r5=0xDEADBEEF port 0, read r5 next cycle -> rd_data=0xDEADBEEF one cycle after read address.
REQ-037 Same cycle: wr0 r3=0x11, wr1 r3=0x22, read r3 -> rd_data=0x22 next cycle; later read r3 -> 0x22.
REQ-038 Write r0=0xFFFF (ZERO_REG=1), read r0 -> 0, rd_pending 0, pending_count 0.
REQ-039 Reserve r7 -> grant=1, count=1; reserve r7 again -> grant=0; write r7=0x5 -> count=0; read r7 -> 0x5, rd_pending 0.
REQ-040 Reserve r2 and r4, then flush with reserve r9 same cycle -> grant=0, count=0, all rd_pending 0.
REQ-041 Reserve r1, write r1, assert reset_n=0 mid-stream -> all outputs 0 immediately; after release read r1 -> 0.

Source files
------------

// File: rtl/w0rm_core_regfile_scoreboard.sv
// Multi-ported register file with per-register pending (scoreboard) bits.
// Reads are registered with write-before-read bypass. Reserves mark registers
// pending, writes clear them, and flush clears them all.
module w0rm_core_regfile_scoreboard #(
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned NUM_REGISTERS   = 16,
   parameter int unsigned NUM_READ_PORTS  = 2,
   parameter int unsigned NUM_WRITE_PORTS = 2,
   parameter int unsigned ZERO_REG        = 1,
   localparam int unsigned A = (NUM_REGISTERS > 1) ? $clog2(NUM_REGISTERS) : 1,
   localparam int unsigned C = A + 1
) (
   input  logic                                  clk,
   input  logic                                  reset_n,
   input  logic [NUM_READ_PORTS*A-1:0]           rd_addr,
   output logic [NUM_READ_PORTS*DATA_WIDTH-1:0]  rd_data,
   output logic [NUM_READ_PORTS-1:0]             rd_pending,
   input  logic [NUM_WRITE_PORTS-1:0]            wr_enable,
   input  logic [NUM_WRITE_PORTS*A-1:0]          wr_addr,
   input  logic [NUM_WRITE_PORTS*DATA_WIDTH-1:0] wr_data,
   input  logic                                  rsv_enable,
   input  logic [A-1:0]                          rsv_addr,
   output logic                                  rsv_grant,
   input  logic                                  flush,
   output logic [C-1:0]                          pending_count
);

   localparam bit ZERO_HW = (ZERO_REG != 0);

   logic [DATA_WIDTH-1:0]                 regs_q [NUM_REGISTERS];
   logic [DATA_WIDTH-1:0]                 regs_d [NUM_REGISTERS];
   logic [NUM_REGISTERS-1:0]              pending_q, pending_d;
   logic [NUM_READ_PORTS*DATA_WIDTH-1:0]  rd_data_q, rd_data_d;
   logic [NUM_READ_PORTS-1:0]             rd_pending_q, rd_pending_d;
   logic [C-1:0]                          count_q, count_d;
   logic                                  rsv_set;

   // Reserve acceptance from pre-edge pending state; never granted in reset.
   assign rsv_grant = reset_n & rsv_enable & ~pending_q[rsv_addr] & ~flush;

   // A granted reserve of the hardwired zero register marks nothing.
   assign rsv_set = rsv_grant & ~(ZERO_HW & (rsv_addr == '0));

   // Next array/pending state; bypassed read data is simply the post-write array.
   always_comb begin
      regs_d       = regs_q;
      pending_d    = pending_q;
      rd_data_d    = '0;
      rd_pending_d = '0;
      count_d      = '0;

      // Ascending port order makes the highest write port win.
      for (int unsigned j = 0; j < NUM_WRITE_PORTS; j++) begin
         if (wr_enable[j]) begin
            if (!(ZERO_HW && (wr_addr[j*A +: A] == '0))) begin
               regs_d[wr_addr[j*A +: A]] = wr_data[j*DATA_WIDTH +: DATA_WIDTH];
            end
            pending_d[wr_addr[j*A +: A]] = 1'b0;
         end
      end

      // Reserve applied after writes so it wins on a same-register collision.
      if (rsv_set) begin
         pending_d[rsv_addr] = 1'b1;
      end

      if (flush) begin
         pending_d = '0;
      end

      for (int unsigned i = 0; i < NUM_READ_PORTS; i++) begin
         rd_data_d[i*DATA_WIDTH +: DATA_WIDTH] = regs_d[rd_addr[i*A +: A]];
         rd_pending_d[i]                       = pending_d[rd_addr[i*A +: A]];
      end

      for (int unsigned k = 0; k < NUM_REGISTERS; k++) begin
         count_d = count_d + C'(pending_d[k]);
      end
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned k = 0; k < NUM_REGISTERS; k++) begin
            regs_q[k] <= '0;
         end
         pending_q    <= '0;
         rd_data_q    <= '0;
         rd_pending_q <= '0;
         count_q      <= '0;
      end else begin
         regs_q       <= regs_d;
         pending_q    <= pending_d;
         rd_data_q    <= rd_data_d;
         rd_pending_q <= rd_pending_d;
         count_q      <= count_d;
      end
   end

   assign rd_data       = rd_data_q;
   assign rd_pending    = rd_pending_q;
   assign pending_count = count_q;

endmodule

// File: tb/tb_w0rm_core_regfile_scoreboard.sv
// Directed bench for the register file scoreboard (default parameters).
module tb_w0rm_core_regfile_scoreboard;

   logic        clk;
   logic        reset_n;
   logic [7:0]  rd_addr;
   logic [63:0] rd_data;
   logic [1:0]  rd_pending;
   logic [1:0]  wr_enable;
   logic [7:0]  wr_addr;
   logic [63:0] wr_data;
   logic        rsv_enable;
   logic [3:0]  rsv_addr;
   logic        rsv_grant;
   logic        flush;
   logic [4:0]  pending_count;

   int checks = 0;
   int errors = 0;

   w0rm_core_regfile_scoreboard dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .rd_addr       (rd_addr),
      .rd_data       (rd_data),
      .rd_pending    (rd_pending),
      .wr_enable     (wr_enable),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .rsv_enable    (rsv_enable),
      .rsv_addr      (rsv_addr),
      .rsv_grant     (rsv_grant),
      .flush         (flush),
      .pending_count (pending_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_enable  = 2'b00;
      rsv_enable = 1'b0;
      flush      = 1'b0;
   endtask

   initial begin
      reset_n    = 1'b0;
      rd_addr    = '0;
      wr_enable  = '0;
      wr_addr    = '0;
      wr_data    = '0;
      rsv_enable = 1'b0;
      rsv_addr   = '0;
      flush      = 1'b0;

      // Reset: activity ignored, outputs zero, no grant
      wr_enable  = 2'b01;
      wr_addr    = 8'h05;
      wr_data    = 64'h0000_0000_1234_5678;
      rsv_enable = 1'b1;
      rsv_addr   = 4'd3;
      #3;
      check("rst_grant", 64'(rsv_grant), 64'd0);
      tick();
      tick();
      check("rst_rd_data", rd_data, 64'd0);
      check("rst_rd_pending", 64'(rd_pending), 64'd0);
      check("rst_count", 64'(pending_count), 64'd0);
      check("rst_grant2", 64'(rsv_grant), 64'd0);
      idle();
      reset_n = 1'b1;

      // First read after reset returns zero
      rd_addr = 8'h35;
      tick();
      check("post_rst_rd5", 64'(rd_data[31:0]), 64'd0);
      check("post_rst_rd3", 64'(rd_data[63:32]), 64'd0);
      check("post_rst_pend", 64'(rd_pending), 64'd0);

      // Write r5 then read it
      wr_enable = 2'b01;
      wr_addr   = 8'h05;
      wr_data   = 64'h0000_0000_DEAD_BEEF;
      rd_addr   = 8'h11;
      tick();
      idle();
      rd_addr = 8'h05;
      tick();
      check("rd_r5", 64'(rd_data[31:0]), 64'hDEAD_BEEF);

      // Same-cycle write/read bypass on port 1
      wr_enable = 2'b01;
      wr_addr   = 8'h06;
      wr_data   = 64'h0000_0000_0000_1234;
      rd_addr   = 8'h60;
      tick();
      idle();
      check("bypass_r6", 64'(rd_data[63:32]), 64'h1234);
      check("bypass_p0_r0", 64'(rd_data[31:0]), 64'd0);

      // Dual write to r3, higher port wins (bypass and array)
      wr_enable = 2'b11;
      wr_addr   = 8'h33;
      wr_data   = 64'h0000_0022_0000_0011;
      rd_addr   = 8'h03;
      tick();
      idle();
      check("dual_wr_bypass", 64'(rd_data[31:0]), 64'h22);
      rd_addr = 8'h30;
      tick();
      check("dual_wr_array", 64'(rd_data[63:32]), 64'h22);

      // Zero register ignores writes and bypass
      wr_enable = 2'b10;
      wr_addr   = 8'h00;
      wr_data   = 64'h0000_FFFF_0000_0000;
      rd_addr   = 8'h00;
      tick();
      idle();
      check("r0_no_bypass", 64'(rd_data[63:32]), 64'd0);
      tick();
      check("r0_read", rd_data, 64'd0);
      check("r0_pending", 64'(rd_pending), 64'd0);
      check("r0_count", 64'(pending_count), 64'd0);

      // Reserve r0: granted, sets nothing
      rsv_enable = 1'b1;
      rsv_addr   = 4'd0;
      #1;
      check("rsv_r0_grant", 64'(rsv_grant), 64'd1);
      tick();
      idle();
      check("rsv_r0_count", 64'(pending_count), 64'd0);

      // Reserve r7, re-reserve rejected, write clears
      rsv_enable = 1'b1;
      rsv_addr   = 4'd7;
      rd_addr    = 8'h07;
      #1;
      check("rsv_r7_grant", 64'(rsv_grant), 64'd1);
      tick();
      check("rsv_r7_count", 64'(pending_count), 64'd1);
      check("rsv_r7_rdpend", 64'(rd_pending), 64'b01);
      check("rsv_r7_again", 64'(rsv_grant), 64'd0);
      tick();
      idle();
      check("rsv_r7_again_cnt", 64'(pending_count), 64'd1);
      wr_enable = 2'b01;
      wr_addr   = 8'h07;
      wr_data   = 64'h5;
      tick();
      idle();
      check("wr_r7_count", 64'(pending_count), 64'd0);
      check("wr_r7_rdpend", 64'(rd_pending), 64'b00);
      check("wr_r7_data", 64'(rd_data[31:0]), 64'h5);

      // Reserve and write same register: reserve wins
      rsv_enable = 1'b1;
      rsv_addr   = 4'd8;
      wr_enable  = 2'b10;
      wr_addr    = 8'h80;
      wr_data    = 64'h0000_00AA_0000_0000;
      rd_addr    = 8'h80;
      #1;
      check("rsv_wr_r8_grant", 64'(rsv_grant), 64'd1);
      tick();
      idle();
      check("rsv_wr_r8_count", 64'(pending_count), 64'd1);
      check("rsv_wr_r8_rdpend", 64'(rd_pending), 64'b10);
      check("rsv_wr_r8_data", 64'(rd_data[63:32]), 64'hAA);
      wr_enable = 2'b01;
      wr_addr   = 8'h08;
      wr_data   = 64'hBB;
      tick();
      idle();
      check("wr_r8_clear", 64'(pending_count), 64'd0);

      // Reserve r2, r4, then flush beats reserve r9
      rsv_enable = 1'b1;
      rsv_addr   = 4'd2;
      tick();
      rsv_addr = 4'd4;
      tick();
      check("rsv_r2_r4_count", 64'(pending_count), 64'd2);
      rsv_addr = 4'd9;
      flush    = 1'b1;
      rd_addr  = 8'h42;
      #1;
      check("flush_grant", 64'(rsv_grant), 64'd0);
      tick();
      idle();
      check("flush_count", 64'(pending_count), 64'd0);
      check("flush_rdpend", 64'(rd_pending), 64'b00);
      rd_addr = 8'h95;
      tick();
      check("flush_keeps_r5", 64'(rd_data[31:0]), 64'hDEAD_BEEF);
      check("flush_r9_clear", 64'(rd_pending), 64'b00);

      // Reserve r1, write r1, reserve r10, then async reset mid-cycle
      rsv_enable = 1'b1;
      rsv_addr   = 4'd1;
      tick();
      idle();
      check("rsv_r1_count", 64'(pending_count), 64'd1);
      wr_enable = 2'b01;
      wr_addr   = 8'h01;
      wr_data   = 64'hAB;
      rd_addr   = 8'hA1;
      tick();
      idle();
      check("wr_r1_data", 64'(rd_data[31:0]), 64'hAB);
      rsv_enable = 1'b1;
      rsv_addr   = 4'd10;
      tick();
      idle();
      check("rsv_r10_count", 64'(pending_count), 64'd1);
      check("rsv_r10_rdpend", 64'(rd_pending), 64'b10);
      #2;
      reset_n = 1'b0;
      #1;
      check("midrst_rd_data", rd_data, 64'd0);
      check("midrst_rdpend", 64'(rd_pending), 64'd0);
      check("midrst_count", 64'(pending_count), 64'd0);
      tick();
      reset_n = 1'b1;
      rd_addr = 8'h51;
      tick();
      check("after_rst_r1", 64'(rd_data[31:0]), 64'd0);
      check("after_rst_r5", 64'(rd_data[63:32]), 64'd0);
      check("after_rst_pend", 64'(rd_pending), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
